// File: rtl/cache_arbiter_pkg.sv
// Shared types and line geometry for the I/D cache arbiter and its line buffer.
// Holds the arbiter state encoding, the grant side and the line-address alignment helper.
package rv32i_types;

    localparam int BEAT_W        = 64;
    localparam int BURST_N       = 4;
    localparam int LINE_W        = BEAT_W * BURST_N;
    localparam int LINE_OFFSET_W = 5;
    localparam logic [31:0] LINE_ADDR_MASK = 32'hFFFF_FFE0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        I_READ  = 3'd1,
        D_READ  = 3'd2,
        D_WRITE = 3'd3,
        RESP    = 3'd4
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return addr & LINE_ADDR_MASK;
    endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of cache-side and physical-memory-side signals around the arbiter.
// slave = arbiter view, master = caches plus memory seen from outside.
interface cache_arbiter_if
    import rv32i_types::*;
#(
    parameter int BEAT_WIDTH = BEAT_W,
    parameter int BURST_LEN  = BURST_N
);
    localparam int LINE_WIDTH = BEAT_WIDTH * BURST_LEN;

    // Handshake: a cache raises read/write with a stable address (and wdata) and
    // holds it until its one-cycle resp, dropping it the cycle after. Memory
    // answers a held pmem_read/pmem_write with one pmem_resp pulse per beat.
    logic                  i_read;
    logic [31:0]           i_address;
    logic [LINE_WIDTH-1:0] i_rdata;
    logic                  i_resp;

    logic                  d_read;
    logic                  d_write;
    logic [31:0]           d_address;
    logic [LINE_WIDTH-1:0] d_wdata;
    logic [LINE_WIDTH-1:0] d_rdata;
    logic                  d_resp;

    logic                  pmem_read;
    logic                  pmem_write;
    logic [31:0]           pmem_address;
    logic [BEAT_WIDTH-1:0] pmem_wdata;
    logic [BEAT_WIDTH-1:0] pmem_rdata;
    logic                  pmem_resp;

    modport slave (
        input  i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        output i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output i_read, i_address, d_read, d_write, d_address, d_wdata,
               pmem_rdata, pmem_resp,
        input  i_rdata, i_resp, d_rdata, d_resp,
               pmem_read, pmem_write, pmem_address, pmem_wdata
    );

endinterface

// File: rtl/cache_arbiter_burst_line_buffer.sv
// One cache line held as BURST_LEN beats: full-line load for writebacks,
// per-beat write for read fills, and a beat-select mux for write bursts.
module burst_line_buffer
    import rv32i_types::*;
#(
    parameter int BEAT_WIDTH = BEAT_W,
    parameter int BURST_LEN  = BURST_N,
    parameter int IDX_W      = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_load,
    input  logic [BEAT_WIDTH*BURST_LEN-1:0] i_load_line,
    input  logic                            i_beat_we,
    input  logic [IDX_W-1:0]                i_beat_idx,
    input  logic [BEAT_WIDTH-1:0]           i_beat_data,
    output logic [BEAT_WIDTH*BURST_LEN-1:0] o_line,
    output logic [BEAT_WIDTH-1:0]           o_beat
);

    logic [BURST_LEN-1:0][BEAT_WIDTH-1:0] r_line;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_line <= '0;
        end else if (i_load) begin
            r_line <= i_load_line;
        end else if (i_beat_we) begin
            r_line[i_beat_idx] <= i_beat_data;
        end
    end

    assign o_line = r_line;
    assign o_beat = r_line[i_beat_idx];

endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter between an I-cache and a D-cache sharing one burst-mode
// physical memory port; one line transaction in flight at a time.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int BEAT_WIDTH = BEAT_W,
    parameter int BURST_LEN  = BURST_N
) (
    input  logic       clk,
    input  logic       reset,
    cache_arbiter_if.slave bus,
    output arb_state_t o_dbg_state
);

    localparam int BEAT_IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BURST_LEN - 1);

    arb_state_t              r_state;
    arb_state_t              w_next_state;
    grant_t                  r_last_grant;
    logic [31:0]             r_addr;
    logic [BEAT_IDX_W-1:0]   r_beat;

    logic                    w_i_req;
    logic                    w_d_req;
    logic                    w_grant;
    grant_t                  w_grant_side;
    logic                    w_burst;
    logic                    w_beat_done;
    logic                    w_last_beat;
    logic                    w_load;
    logic                    w_beat_we;
    logic [BEAT_WIDTH*BURST_LEN-1:0] w_line;
    logic [BEAT_WIDTH-1:0]   w_beat_rd;

    assign w_i_req     = bus.i_read;
    assign w_d_req     = bus.d_read | bus.d_write;
    assign w_burst     = r_state inside {I_READ, D_READ, D_WRITE};
    assign w_beat_done = w_burst && bus.pmem_resp;
    assign w_last_beat = w_beat_done && (r_beat == LAST_BEAT);
    assign w_load      = w_grant && (w_next_state == D_WRITE);
    assign w_beat_we   = bus.pmem_resp && (r_state == I_READ || r_state == D_READ);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_grant         = 1'b0;
        w_grant_side    = r_last_grant;
        bus.pmem_read   = 1'b0;
        bus.pmem_write  = 1'b0;
        bus.i_resp      = 1'b0;
        bus.d_resp      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_i_req || w_d_req) begin
                    w_grant = 1'b1;
                    // On a tie the side that did not win last time goes first.
                    if (w_i_req && w_d_req) begin
                        w_grant_side = (r_last_grant == GRANT_I) ? GRANT_D : GRANT_I;
                    end else begin
                        w_grant_side = w_d_req ? GRANT_D : GRANT_I;
                    end
                    if (w_grant_side == GRANT_I) begin
                        w_next_state = I_READ;
                    end else if (bus.d_write) begin
                        w_next_state = D_WRITE;
                    end else begin
                        w_next_state = D_READ;
                    end
                end
            end
            I_READ, D_READ: begin
                bus.pmem_read = 1'b1;
                if (w_last_beat) begin
                    w_next_state = RESP;
                end
            end
            D_WRITE: begin
                bus.pmem_write = 1'b1;
                if (w_last_beat) begin
                    w_next_state = RESP;
                end
            end
            RESP: begin
                if (r_last_grant == GRANT_I) begin
                    bus.i_resp = 1'b1;
                end else begin
                    bus.d_resp = 1'b1;
                end
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // r_last_grant doubles as the side being served, which selects the RESP pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= GRANT_I;
            r_addr       <= '0;
            r_beat       <= '0;
        end else begin
            if (w_grant) begin
                r_last_grant <= w_grant_side;
                r_addr       <= line_align((w_grant_side == GRANT_I) ? bus.i_address : bus.d_address);
            end
            if (w_beat_done) begin
                r_beat <= w_last_beat ? '0 : r_beat + BEAT_IDX_W'(1);
            end
        end
    end

    burst_line_buffer #(
        .BEAT_WIDTH (BEAT_WIDTH),
        .BURST_LEN  (BURST_LEN),
        .IDX_W      (BEAT_IDX_W)
    ) u_line_buf (
        .clk         (clk),
        .reset       (reset),
        .i_load      (w_load),
        .i_load_line (bus.d_wdata),
        .i_beat_we   (w_beat_we),
        .i_beat_idx  (r_beat),
        .i_beat_data (bus.pmem_rdata),
        .o_line      (w_line),
        .o_beat      (w_beat_rd)
    );

    assign bus.i_rdata      = w_line;
    assign bus.d_rdata      = w_line;
    assign bus.pmem_address = r_addr;
    assign bus.pmem_wdata   = w_beat_rd;
    assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: burst memory model with random beat latency and
// stray pulses, plus a scoreboard of expected line transactions in grant order.
module tb_cache_arbiter;
    import rv32i_types::*;

    localparam int BW    = 64;
    localparam int BL    = 4;
    localparam int LW    = BW * BL;
    localparam int EXP_W = 2 + 32 + LW;   // {side_d, is_write, line_addr, line}

    logic       clk = 1'b0;
    logic       reset;
    arb_state_t dbg_state;

    cache_arbiter_if #(.BEAT_WIDTH(BW), .BURST_LEN(BL)) bus();

    cache_arbiter #(.BEAT_WIDTH(BW), .BURST_LEN(BL)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [EXP_W-1:0] exp_q[$];
    int max_delay   = 0;
    int burst_beats = 0;
    bit use_tbl     = 1'b0;
    logic [BW-1:0] tbl [BL];

    task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] mem_beat(input logic [31:0] addr, input int k);
        if (use_tbl) return tbl[k];
        return {addr ^ 32'h5A5A_0000, 32'(k + 1) * 32'h0101_0101};
    endfunction

    task automatic push_exp(input logic side_d, input logic wr, input logic [31:0] addr,
                            input logic [LW-1:0] wline);
        logic [31:0]   a;
        logic [LW-1:0] line;
        a = {addr[31:5], 5'b0};
        line = wline;
        if (!wr) begin
            for (int k = 0; k < BL; k++) line[k*BW +: BW] = mem_beat(a, k);
        end
        exp_q.push_back({side_d, wr, a, line});
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_i(input logic [31:0] addr);
        bus.i_read    = 1'b1;
        bus.i_address = addr;
    endtask

    task automatic drive_d(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [LW-1:0] wdata);
        bus.d_read    = rd;
        bus.d_write   = wr;
        bus.d_address = addr;
        bus.d_wdata   = wdata;
    endtask

    task automatic wait_drain(input string tag);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < 400) begin
            @(posedge clk);
            c++;
        end
        repeat (3) @(posedge clk);
        #1;
        check({"drain_", tag}, LW'(exp_q.size()), '0);
        if (exp_q.size() != 0) begin
            exp_q.delete();
            bus.i_read  = 1'b0;
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
        end
    endtask

    // ---------------- physical memory model ----------------
    initial begin
        int mem_k;
        int delay_cnt;
        logic [EXP_W-1:0] e;
        mem_k = 0;
        delay_cnt = 0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.pmem_resp  = 1'b0;
            bus.pmem_rdata = {$urandom, $urandom};
            if (reset || !(bus.pmem_read || bus.pmem_write)) begin
                mem_k     = 0;
                delay_cnt = $urandom_range(0, max_delay);
                bus.pmem_resp = 1'($urandom_range(0, 1));   // stray pulses must be ignored
            end else if (delay_cnt != 0) begin
                delay_cnt--;
            end else begin
                if (exp_q.size() != 0 && mem_k < BL) begin
                    e = exp_q[0];
                    if (!e[EXP_W-2]) begin
                        bus.pmem_rdata = mem_beat(e[LW+31:LW], mem_k);
                    end else begin
                        check("pmem_wdata", LW'(bus.pmem_wdata), LW'(e[mem_k*BW +: BW]));
                    end
                end
                bus.pmem_resp = 1'b1;
                mem_k++;
                burst_beats++;
                delay_cnt = $urandom_range(0, max_delay);
            end
        end
    end

    // ---------------- monitor / scoreboard compare ----------------
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("onehot", LW'($countones({bus.pmem_read, bus.pmem_write, bus.i_resp, bus.d_resp}) <= 1), LW'(1));
                if (bus.pmem_read || bus.pmem_write) begin
                    if (exp_q.size() == 0) begin
                        check("burst_unexpected", LW'({bus.pmem_read, bus.pmem_write}), '0);
                    end else begin
                        e = exp_q[0];
                        check("pmem_addr", LW'(bus.pmem_address), LW'(e[LW+31:LW]));
                        check("pmem_write", LW'(bus.pmem_write), LW'(e[EXP_W-2]));
                        check("pmem_read", LW'(bus.pmem_read), LW'(!e[EXP_W-2]));
                    end
                end
                if (bus.i_resp || bus.d_resp) begin
                    if (exp_q.size() == 0) begin
                        check("resp_unexpected", LW'({bus.i_resp, bus.d_resp}), '0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_d", LW'(bus.d_resp), LW'(e[EXP_W-1]));
                        check("resp_i", LW'(bus.i_resp), LW'(!e[EXP_W-1]));
                        check("rdata", e[EXP_W-1] ? bus.d_rdata : bus.i_rdata, e[LW-1:0]);
                        check("beats", LW'(burst_beats), LW'(BL));
                        burst_beats = 0;
                        @(posedge clk);
                        #1;
                        if (e[EXP_W-1]) begin
                            bus.d_read  = 1'b0;
                            bus.d_write = 1'b0;
                        end else begin
                            bus.i_read = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [LW-1:0] wdata;
        logic [31:0]   addr;
        logic          side_d;
        logic          wr;
        int            c;

        reset         = 1'b1;
        bus.i_read    = 1'b0;
        bus.i_address = '0;
        bus.d_read    = 1'b0;
        bus.d_write   = 1'b0;
        bus.d_address = '0;
        bus.d_wdata   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("rst_state", LW'(dbg_state), LW'(IDLE));
        check("rst_pmem_read", LW'(bus.pmem_read), '0);
        check("rst_pmem_write", LW'(bus.pmem_write), '0);
        check("rst_i_resp", LW'(bus.i_resp), '0);
        check("rst_d_resp", LW'(bus.d_resp), '0);
        check("rst_pmem_addr", LW'(bus.pmem_address), '0);
        check("rst_pmem_wdata", LW'(bus.pmem_wdata), '0);
        check("rst_i_rdata", bus.i_rdata, '0);
        check("rst_d_rdata", bus.d_rdata, '0);

        // Tie right after reset: D first, then I.
        @(posedge clk);
        #1;
        drive_i(32'h0000_2004);
        drive_d(1'b1, 1'b0, 32'h0000_3018, '0);
        push_exp(1'b1, 1'b0, 32'h0000_3018, '0);
        push_exp(1'b0, 1'b0, 32'h0000_2004, '0);
        wait_drain("tie_after_reset");

        // Single instruction fill with fixed beats.
        tbl[0] = 64'h1111_1111_1111_1111;
        tbl[1] = 64'h2222_2222_2222_2222;
        tbl[2] = 64'h3333_3333_3333_3333;
        tbl[3] = 64'h4444_4444_4444_4444;
        use_tbl = 1'b1;
        @(posedge clk);
        #1;
        drive_i(32'h0000_1234);
        push_exp(1'b0, 1'b0, 32'h0000_1234, '0);
        wait_drain("i_fill");
        use_tbl = 1'b0;

        // Writeback burst, low beat first.
        wdata = {64'hAAAA_AAAA_AAAA_AAA3, 64'hAAAA_AAAA_AAAA_AAA2,
                 64'hAAAA_AAAA_AAAA_AAA1, 64'hBBBB_BBBB_BBBB_BBB0};
        @(posedge clk);
        #1;
        drive_d(1'b0, 1'b1, 32'h8000_0040, wdata);
        push_exp(1'b1, 1'b1, 32'h8000_0040, wdata);
        wait_drain("d_write");

        // Last grant was D, so a tie now serves I first.
        @(posedge clk);
        #1;
        drive_i(32'h0001_0000);
        drive_d(1'b1, 1'b0, 32'h0002_0020, '0);
        push_exp(1'b0, 1'b0, 32'h0001_0000, '0);
        push_exp(1'b1, 1'b0, 32'h0002_0020, '0);
        wait_drain("tie_round_robin");

        // d_read and d_write together behave as a writeback.
        wdata = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        drive_d(1'b1, 1'b1, 32'h0000_7777, wdata);
        push_exp(1'b1, 1'b1, 32'h0000_7777, wdata);
        wait_drain("rd_wr_both");

        // Random beat latency on random transactions.
        max_delay = 5;
        for (int t = 0; t < 8; t++) begin
            side_d = 1'($urandom_range(0, 1));
            wr     = 1'($urandom_range(0, 1));
            addr   = $urandom;
            wdata  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            if (side_d) begin
                drive_d(!wr, wr, addr, wdata);
                push_exp(1'b1, wr, addr, wdata);
            end else begin
                drive_i(addr);
                push_exp(1'b0, 1'b0, addr, '0);
            end
            wait_drain("random_delay");
        end
        max_delay = 0;

        // Reset in the middle of a read burst discards it.
        @(posedge clk);
        #1;
        drive_i(32'h0000_5008);
        push_exp(1'b0, 1'b0, 32'h0000_5008, '0);
        c = 0;
        while (burst_beats < 2 && c < 100) begin
            @(posedge clk);
            #2;
            c++;
        end
        check("rst_mid_beats", LW'(burst_beats), LW'(2));
        @(posedge clk);
        @(negedge clk);
        reset      = 1'b1;
        bus.i_read = 1'b0;
        @(posedge clk);
        #2;
        void'(exp_q.pop_front());
        burst_beats = 0;
        @(negedge clk);
        check("rst_mid_pmem_read", LW'(bus.pmem_read), '0);
        check("rst_mid_i_resp", LW'(bus.i_resp), '0);
        check("rst_mid_state", LW'(dbg_state), LW'(IDLE));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_line_clear", bus.i_rdata, '0);

        @(posedge clk);
        #1;
        drive_i(32'h0000_6040);
        push_exp(1'b0, 1'b0, 32'h0000_6040, '0);
        wait_drain("after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
